sr_fifo_arbiter: RTL and testbench
==================================

SR_FIFO_ARBITER -- requirements
Module: sr_fifo_arbiter

Interface
REQ-001 Parameter: DEPTH, default 8, FIFO entry count; power of two, at least 2.
REQ-002 Parameter: WIDTH, default 16, data width in bits.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst  input  1  reset, synchronous, active-high.
REQ-005 Port: cpu_push  input  1  CPU push request (push instruction decoded).
REQ-006 Port: cpu_pop  input  1  CPU pop request (pop instruction decoded).
REQ-007 Port: cpu_din  input  WIDTH  CPU push data.
REQ-008 Port: cpu_dout  output  WIDTH  CPU pop data, valid in the grant cycle.
REQ-009 Port: cpu_stall  output  1  CPU request not granted this cycle; the CPU SHALL hold its PC and instruction.
REQ-010 Port: ext_req  input  1  external requester operation request.
REQ-011 Port: ext_wr  input  1  external operation type: 1 is push, 0 is pop.
REQ-012 Port: ext_din  input  WIDTH  external push data.
REQ-013 Port: ext_ack  output  1  external request granted this cycle.
REQ-014 Port: ext_dout  output  WIDTH  external pop data, valid when ext_ack is high.
REQ-015 Port: count  output  log2(DEPTH)+1  current occupancy.
REQ-016 Port: full, empty  output  1 each  occupancy equals DEPTH, occupancy equals 0.
REQ-017 Port: err_clr  input  1  clears the sticky error flags.
REQ-018 Port: ovf_err, udf_err  output  1 each  sticky overflow and underflow flags.

Function
REQ-019 Storage SHALL be DEPTH x WIDTH, with read and write pointers of log2(DEPTH) bits that wrap from DEPTH-1 to 0.
REQ-020 The block SHALL grant at most one operation per cycle; the grant is combinational in the request cycle and the state update happens at the next rising edge.
REQ-021 CPU request = cpu_push | cpu_pop; if both are high, the operation SHALL be a push and the pop SHALL be ignored.
REQ-022 With a single requester active, that requester SHALL be granted.
REQ-023 On contention, grant SHALL go to the requester selected by the 1-bit prio register: 0 selects the CPU, 1 selects external.
REQ-024 After a contention cycle, prio SHALL switch to the losing requester; prio SHALL be unchanged in non-contention cycles.
REQ-025 cpu_stall SHALL equal CPU request AND NOT CPU grant; ext_ack SHALL equal ext_req AND external grant.
REQ-026 A waiting requester SHALL be granted no later than the next cycle, provided it holds its request.
REQ-027 Pop data SHALL be first-word fall-through: cpu_dout and ext_dout SHALL equal the entry at the read pointer when not empty, and 0 when empty.
REQ-028 A granted push when not full SHALL write the entry at the write pointer, increment the write pointer, and increment count.
REQ-029 A granted pop when not empty SHALL increment the read pointer and decrement count.
REQ-030 A granted push when full SHALL still be granted with no stall, SHALL drop the data, leave the pointers and count unchanged, and set ovf_err.
REQ-031 A granted pop when empty SHALL still be granted, SHALL return 0, leave the pointers and count unchanged, and set udf_err.
REQ-032 err_clr SHALL clear both flags at the next edge; if a flag-setting event occurs in the same cycle, the set SHALL win.
REQ-033 full, empty and count SHALL be registered-state derived and SHALL change only at a clock edge.

Reset
REQ-034 While rst is high at a rising edge, the block SHALL load: pointers 0, count 0, prio 0, ovf_err 0, udf_err 0.
REQ-035 With those values, full SHALL read 0 and empty SHALL read 1.
REQ-036 While rst is high, ext_ack and cpu_stall SHALL be 0 and no storage write SHALL occur.
REQ-037 A reset asserted mid-operation SHALL discard all contents; the data array itself need not be cleared.

Verification
REQ-038 Reset, then CPU push 0x1234 then CPU pop -> cpu_stall 0 in both cycles, count goes 1 then 0, cpu_dout = 0x1234 in the pop cycle.
REQ-039 Both requesters push every cycle from reset, CPU data 0xA000+n, external data 0xB000+n -> grants alternate CPU, ext, CPU, ...; cpu_stall is high every other CPU cycle; contents read back in grant order.
REQ-040 Push 8 entries, then a 9th push -> full 1, count 8, ovf_err 1, 9th data absent; 8 pops return the original order with wrap.
REQ-041 Pop when empty -> dout 0, udf_err 1, count 0; err_clr pulse -> udf_err 0; err_clr together with another empty pop -> udf_err stays 1.
REQ-042 rst asserted with 3 entries and both requests pending -> ext_ack 0, cpu_stall 0; next cycle count 0, empty 1, prio 0.
REQ-043 cpu_push and cpu_pop both high with count 2 -> push performed, count 3.

Source files
------------

// File: rtl/sr_fifo_arbiter_if.sv
// Bus bundle for the two-requester FIFO arbiter.
// The slave modport is the arbiter side; the master modport is the requester/bench side.
interface sr_fifo_arbiter_if #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    // CPU requester
    logic             cpu_push;
    logic             cpu_pop;
    logic [WIDTH-1:0] cpu_din;
    logic [WIDTH-1:0] cpu_dout;
    logic             cpu_stall;

    // External requester
    logic             ext_req;
    logic             ext_wr;
    logic [WIDTH-1:0] ext_din;
    logic             ext_ack;
    logic [WIDTH-1:0] ext_dout;

    // Status and error flags
    logic [CW-1:0]    count;
    logic             full;
    logic             empty;
    logic             err_clr;
    logic             ovf_err;
    logic             udf_err;

    modport master (
        output cpu_push, cpu_pop, cpu_din,
        input  cpu_dout, cpu_stall,
        output ext_req, ext_wr, ext_din,
        input  ext_ack, ext_dout,
        input  count, full, empty,
        output err_clr,
        input  ovf_err, udf_err
    );

    modport slave (
        input  cpu_push, cpu_pop, cpu_din,
        output cpu_dout, cpu_stall,
        input  ext_req, ext_wr, ext_din,
        output ext_ack, ext_dout,
        output count, full, empty,
        input  err_clr,
        output ovf_err, udf_err
    );
endinterface

// File: rtl/sr_fifo_arbiter.sv
// Single-port FIFO shared by a CPU and an external requester.
// One operation is granted per cycle; contention alternates via a 1-bit
// priority register that flips to the loser after every contended cycle.
// Pop data is first-word fall-through; overflow/underflow are sticky.
module sr_fifo_arbiter #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    sr_fifo_arbiter_if.slave     bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    // Registered state
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;
    logic             prio_q,   prio_d;
    logic             ovf_q,    ovf_d;
    logic             udf_q,    udf_d;

    // Combinational arbitration / datapath signals
    logic             cpu_req_s;
    logic             contention_s;
    logic             cpu_gnt_s;
    logic             ext_gnt_s;
    logic             op_valid_s;
    logic             op_push_s;
    logic [WIDTH-1:0] op_din_s;
    logic             full_s;
    logic             empty_s;
    logic             wr_en_s;
    logic             rd_en_s;
    logic             ovf_set_s;
    logic             udf_set_s;
    logic [WIDTH-1:0] head_s;

    // Status derived from registered occupancy only
    always_comb begin
        full_s  = (count_q == DEPTH_C);
        empty_s = (count_q == {CW{1'b0}});
    end

    // Arbitration: lone requester wins, contention resolved by prio_q, nothing granted in reset
    always_comb begin
        cpu_req_s    = bus.cpu_push | bus.cpu_pop;
        contention_s = 1'b0;
        cpu_gnt_s    = 1'b0;
        ext_gnt_s    = 1'b0;
        if (rst) begin
            contention_s = 1'b0;
        end else if (cpu_req_s && bus.ext_req) begin
            contention_s = 1'b1;
            if (prio_q == 1'b0) begin
                cpu_gnt_s = 1'b1;
            end else begin
                ext_gnt_s = 1'b1;
            end
        end else if (cpu_req_s) begin
            cpu_gnt_s = 1'b1;
        end else if (bus.ext_req) begin
            ext_gnt_s = 1'b1;
        end else begin
            contention_s = 1'b0;
        end
    end

    // Select the granted operation; a CPU push outranks a simultaneous CPU pop
    always_comb begin
        op_valid_s = 1'b0;
        op_push_s  = 1'b0;
        op_din_s   = {WIDTH{1'b0}};
        if (cpu_gnt_s) begin
            op_valid_s = 1'b1;
            op_push_s  = bus.cpu_push;
            op_din_s   = bus.cpu_din;
        end else if (ext_gnt_s) begin
            op_valid_s = 1'b1;
            op_push_s  = bus.ext_wr;
            op_din_s   = bus.ext_din;
        end else begin
            op_valid_s = 1'b0;
        end
    end

    // Qualify the granted operation against occupancy; illegal ones only raise a flag
    always_comb begin
        wr_en_s   = op_valid_s &  op_push_s & ~full_s;
        rd_en_s   = op_valid_s & ~op_push_s & ~empty_s;
        ovf_set_s = op_valid_s &  op_push_s &  full_s;
        udf_set_s = op_valid_s & ~op_push_s &  empty_s;
    end

    // Next-state for pointers, occupancy, priority and sticky flags
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        prio_d   = prio_q;

        if (wr_en_s) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (rd_en_s) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({wr_en_s, rd_en_s})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // The loser of a contended cycle gets priority next time
        if (contention_s) begin
            prio_d = ~prio_q;
        end else begin
            prio_d = prio_q;
        end

        // A set in the same cycle as err_clr takes precedence
        ovf_d = ovf_set_s | (ovf_q & ~bus.err_clr);
        udf_d = udf_set_s | (udf_q & ~bus.err_clr);
    end

    // Control state register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
            prio_q   <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            prio_q   <= prio_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // Storage array write; contents are not reset, occupancy tracking makes them invisible
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[wr_ptr_q] <= op_din_s;
        end
    end

    // Fall-through head word, forced to zero when nothing is stored
    always_comb begin
        if (empty_s) begin
            head_s = {WIDTH{1'b0}};
        end else begin
            head_s = mem_q[rd_ptr_q];
        end
    end

    // Drive the bus outputs
    always_comb begin
        bus.cpu_stall = cpu_req_s & ~cpu_gnt_s & ~rst;
        bus.ext_ack   = bus.ext_req & ext_gnt_s;
        bus.cpu_dout  = head_s;
        bus.ext_dout  = head_s;
        bus.count     = count_q;
        bus.full      = full_s;
        bus.empty     = empty_s;
        bus.ovf_err   = ovf_q;
        bus.udf_err   = udf_q;
    end
endmodule

// File: tb/tb_sr_fifo_arbiter.sv
// Randomised and directed bench for sr_fifo_arbiter with a queue-based reference model.
module tb_sr_fifo_arbiter;
    localparam int DEPTH = 8;
    localparam int WIDTH = 16;

    typedef struct {
        logic             stall;
        logic             ack;
        logic [WIDTH-1:0] dout;
        logic [3:0]       count;
        logic             full;
        logic             empty;
        logic             ovf;
        logic             udf;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    sr_fifo_arbiter_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bif ();

    sr_fifo_arbiter #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif.slave)
    );

    always #5 clk = ~clk;

    // Reference model state
    int               fifo_m[$];
    bit               prio_m;
    bit               ovf_m;
    bit               udf_m;
    bit               last_cpu_gnt;
    exp_t             exp_q[$];

    int total = 0;
    int bad   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: one expectation per driven cycle, compared away from the rising edge
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("cpu_stall", {31'd0, bif.cpu_stall}, {31'd0, e.stall});
            check("ext_ack",   {31'd0, bif.ext_ack},   {31'd0, e.ack});
            check("cpu_dout",  {16'd0, bif.cpu_dout},  {16'd0, e.dout});
            check("ext_dout",  {16'd0, bif.ext_dout},  {16'd0, e.dout});
            check("count",     {28'd0, bif.count},     {28'd0, e.count});
            check("full",      {31'd0, bif.full},      {31'd0, e.full});
            check("empty",     {31'd0, bif.empty},     {31'd0, e.empty});
            check("ovf_err",   {31'd0, bif.ovf_err},   {31'd0, e.ovf});
            check("udf_err",   {31'd0, bif.udf_err},   {31'd0, e.udf});
        end
    end

    // Drive one cycle of stimulus and push the model's expectation for it
    task automatic cyc(input bit p, input bit q, input logic [WIDTH-1:0] d,
                       input bit er, input bit ew, input logic [WIDTH-1:0] ed,
                       input bit clr, input bit r, input bit chk);
        exp_t e;
        bit cg, eg, creq, ispush, so, su;
        int data;
        @(posedge clk);
        #1;
        rst          = r;
        bif.cpu_push = p;
        bif.cpu_pop  = q;
        bif.cpu_din  = d;
        bif.ext_req  = er;
        bif.ext_wr   = ew;
        bif.ext_din  = ed;
        bif.err_clr  = clr;

        e.dout  = (fifo_m.size() == 0) ? 16'h0000 : 16'(fifo_m[0]);
        e.count = 4'(fifo_m.size());
        e.full  = (fifo_m.size() == DEPTH);
        e.empty = (fifo_m.size() == 0);
        e.ovf   = ovf_m;
        e.udf   = udf_m;
        creq    = p | q;
        cg = 1'b0;
        eg = 1'b0;
        if (r) begin
            e.stall = 1'b0;
            e.ack   = 1'b0;
            fifo_m.delete();
            prio_m = 1'b0;
            ovf_m  = 1'b0;
            udf_m  = 1'b0;
        end else begin
            if (creq && er) begin
                cg = !prio_m;
                eg = prio_m;
                prio_m = !prio_m;
            end else begin
                cg = creq;
                eg = er;
            end
            e.stall = creq && !cg;
            e.ack   = eg;
            so = 1'b0;
            su = 1'b0;
            if (cg || eg) begin
                ispush = cg ? p : ew;
                data   = cg ? int'(d) : int'(ed);
                if (ispush) begin
                    if (fifo_m.size() == DEPTH) so = 1'b1;
                    else fifo_m.push_back(data);
                end else begin
                    if (fifo_m.size() == 0) su = 1'b1;
                    else void'(fifo_m.pop_front());
                end
            end
            ovf_m = so || (ovf_m && !clr);
            udf_m = su || (udf_m && !clr);
        end
        last_cpu_gnt = cg;
        if (chk) exp_q.push_back(e);
    endtask

    initial begin
        int na, nb;
        bif.cpu_push = 1'b0; bif.cpu_pop = 1'b0; bif.cpu_din = 16'h0;
        bif.ext_req  = 1'b0; bif.ext_wr  = 1'b0; bif.ext_din = 16'h0;
        bif.err_clr  = 1'b0;

        // Reset: first cycle state unknown, second cycle shows reset values
        cyc(0, 0, 16'h0, 0, 0, 16'h0, 0, 1, 0);
        cyc(0, 0, 16'h0, 0, 0, 16'h0, 0, 1, 1);
        cyc(0, 0, 16'h0, 0, 0, 16'h0, 0, 0, 1);

        // Simple push then pop
        cyc(1, 0, 16'h1234, 0, 0, 16'h0, 0, 0, 1);
        cyc(0, 1, 16'h0,    0, 0, 16'h0, 0, 0, 1);
        cyc(0, 0, 16'h0,    0, 0, 16'h0, 0, 0, 1);

        // Both push every cycle: alternating grants, held data while stalled
        na = 0; nb = 0;
        for (int i = 0; i < 9; i++) begin
            cyc(1, 0, 16'hA000 + 16'(na), 1, 1, 16'hB000 + 16'(nb), 0, 0, 1);
            if (last_cpu_gnt) na++;
            else nb++;
        end
        for (int i = 0; i < 9; i++) cyc(0, 0, 16'h0, 1, 0, 16'h0, 0, 0, 1);
        cyc(0, 0, 16'h0, 0, 0, 16'h0, 1, 0, 1);

        // Offset pointers, then fill past full for wrap and overflow
        for (int i = 0; i < 3; i++) cyc(1, 0, 16'h0C00 + 16'(i), 0, 0, 16'h0, 0, 0, 1);
        for (int i = 0; i < 3; i++) cyc(0, 1, 16'h0, 0, 0, 16'h0, 0, 0, 1);
        for (int i = 0; i < 9; i++) cyc(1, 0, 16'h5100 + 16'(i), 0, 0, 16'h0, 0, 0, 1);
        cyc(0, 0, 16'h0, 0, 0, 16'h0, 0, 0, 1);
        for (int i = 0; i < 8; i++) cyc(0, 1, 16'h0, 0, 0, 16'h0, 0, 0, 1);

        // Underflow, clear, and clear colliding with a new underflow
        cyc(0, 0, 16'h0, 1, 0, 16'h0, 0, 0, 1);
        cyc(0, 0, 16'h0, 0, 0, 16'h0, 1, 0, 1);
        cyc(0, 0, 16'h0, 0, 0, 16'h0, 0, 0, 1);
        cyc(0, 1, 16'h0, 0, 0, 16'h0, 1, 0, 1);
        cyc(0, 0, 16'h0, 0, 0, 16'h0, 0, 0, 1);

        // Push and pop together performs a push
        cyc(1, 0, 16'h7701, 0, 0, 16'h0, 1, 0, 1);
        cyc(1, 0, 16'h7702, 0, 0, 16'h0, 0, 0, 1);
        cyc(1, 1, 16'h7703, 0, 0, 16'h0, 0, 0, 1);
        cyc(0, 0, 16'h0,    0, 0, 16'h0, 0, 0, 1);

        // Reset mid-operation with both requests pending; CPU must then win contention
        cyc(1, 0, 16'h7704, 1, 1, 16'h8801, 0, 1, 1);
        cyc(1, 0, 16'h7705, 1, 1, 16'h8802, 0, 0, 1);
        cyc(0, 0, 16'h0,    0, 0, 16'h0,    0, 0, 1);

        // Random traffic with occasional reset and error clear
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(0, 99) < 45), ($urandom_range(0, 99) < 40),
                16'($urandom), ($urandom_range(0, 99) < 50), ($urandom_range(0, 99) < 50),
                16'($urandom), ($urandom_range(0, 15) == 0), ($urandom_range(0, 63) == 0), 1);
        end
        cyc(0, 0, 16'h0, 0, 0, 16'h0, 0, 0, 1);

        // Let the monitor drain, bounded
        for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(negedge clk);
        #1;
        check("drain", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
